// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_pkg
// Brief    : Shared UART definitions: FSM state encodings, default frame
//            geometry and a counter-width helper. Used by both the receiver
//            and the transmitter.
// Revision : 1.0 - initial release
// ============================================================================
package uart_pkg;

    // Default frame geometry: 8 data bits, 16 s_tick pulses per bit period.
    localparam int DATA_BITS_DEF  = 8;
    localparam int OVERSAMPLE_DEF = 16;

    // FSM state encodings, shared so the TX and RX debug views use the same
    // numbering.
    localparam int         STATE_W      = 3;
    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_START     = 3'd1;
    localparam logic [2:0] ST_DATA      = 3'd2;
    localparam logic [2:0] ST_STOP      = 3'd3;
    localparam logic [2:0] ST_WAIT_HIGH = 3'd4;

    // Width of a counter that must hold 0..n-1. Never returns less than 1
    // so that degenerate parameter values still give a legal vector.
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_sync2.sv
`default_nettype none
// ============================================================================
// Module   : uart_sync2
// Brief    : Two-flop synchronizer for a single asynchronous input. The
//            reset value is a parameter so idle-high lines (UART rx) and
//            idle-low lines can share the same cell.
// Revision : 1.0 - initial release
// ============================================================================
module uart_sync2 #(
    parameter logic RESET_VALUE = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta;

    // First flop may go metastable; the second gives it a full cycle to settle.
    always_ff @(posedge clk) begin
        if (reset) begin
            meta <= RESET_VALUE;
            q    <= RESET_VALUE;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule
`default_nettype wire

// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx
// Brief    : 8N1-style UART receiver with oversampled start-bit validation,
//            LSB-first data capture and stop-bit checking. Emits a one-cycle
//            rx_done with the byte, or a one-cycle frame_error when the stop
//            bit is sampled low. A break (line held low) is absorbed silently
//            until the line returns high.
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = DATA_BITS_DEF,
    parameter int OVERSAMPLE = OVERSAMPLE_DEF   // must be even and >= 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 s_tick,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] data,
    output logic                 rx_done,
    output logic                 frame_error
);

    localparam int TICK_W = cnt_width(OVERSAMPLE);
    localparam int BIT_W  = cnt_width(DATA_BITS);

    // Mid start bit: half a bit period after the falling edge was seen.
    localparam logic [TICK_W-1:0] TICK_MID  = TICK_W'(OVERSAMPLE / 2 - 1);
    // One full bit period after the previous sample point.
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(OVERSAMPLE - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_BITS - 1);

    // ------------------------------------------------------------------
    // Input synchronizer (idle-high line, so reset to 1)
    // ------------------------------------------------------------------
    logic rx_s;

    uart_sync2 #(
        .RESET_VALUE (1'b1)
    ) u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (rx),
        .q     (rx_s)
    );

    // ------------------------------------------------------------------
    // FSM and datapath state
    // ------------------------------------------------------------------
    logic [STATE_W-1:0]   state,     state_next;
    logic [TICK_W-1:0]    tick_cnt,  tick_next;
    logic [BIT_W-1:0]     bit_cnt,   bit_next;
    logic [DATA_BITS-1:0] shreg,     shreg_next;

    logic done_set;
    logic ferr_set;

    // Shifting right with the new bit at the MSB lands the first (LSB)
    // bit at position 0 once all DATA_BITS bits have been taken.
    logic [DATA_BITS:0] shift_cat;
    assign shift_cat = {rx_s, shreg};

    // State register: FSM state, oversample/bit counters and shift register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_IDLE;
            tick_cnt <= '0;
            bit_cnt  <= '0;
            shreg    <= '0;
        end else begin
            state    <= state_next;
            tick_cnt <= tick_next;
            bit_cnt  <= bit_next;
            shreg    <= shreg_next;
        end
    end

    // Next-state logic: everything advances only on s_tick cycles, and
    // tick_cnt restarts from 0 whenever a sample point is consumed.
    always_comb begin
        state_next = state;
        tick_next  = tick_cnt;
        bit_next   = bit_cnt;
        shreg_next = shreg;

        if (s_tick) begin
            case (state)
                ST_IDLE: begin
                    if (!rx_s) begin
                        state_next = ST_START;
                        tick_next  = '0;
                    end
                end

                ST_START: begin
                    if (tick_cnt == TICK_MID) begin
                        tick_next = '0;
                        if (!rx_s) begin
                            state_next = ST_DATA;
                            bit_next   = '0;
                        end else begin
                            // Line went back high before mid-bit: a glitch.
                            state_next = ST_IDLE;
                        end
                    end else begin
                        tick_next = tick_cnt + 1'b1;
                    end
                end

                ST_DATA: begin
                    if (tick_cnt == TICK_LAST) begin
                        tick_next  = '0;
                        shreg_next = shift_cat[DATA_BITS:1];
                        if (bit_cnt == BIT_LAST) begin
                            state_next = ST_STOP;
                        end else begin
                            bit_next = bit_cnt + 1'b1;
                        end
                    end else begin
                        tick_next = tick_cnt + 1'b1;
                    end
                end

                ST_STOP: begin
                    if (tick_cnt == TICK_LAST) begin
                        tick_next  = '0;
                        state_next = rx_s ? ST_IDLE : ST_WAIT_HIGH;
                    end else begin
                        tick_next = tick_cnt + 1'b1;
                    end
                end

                ST_WAIT_HIGH: begin
                    // Do not look for a new start bit until the line has
                    // been seen idle, so a break yields a single error.
                    if (rx_s) begin
                        state_next = ST_IDLE;
                        tick_next  = '0;
                    end
                end

                default: begin
                    state_next = ST_IDLE;
                    tick_next  = '0;
                    bit_next   = '0;
                end
            endcase
        end
    end

    // Output decode: the stop sample decides between a good byte and a
    // framing error; the two are mutually exclusive by construction.
    always_comb begin
        done_set = 1'b0;
        ferr_set = 1'b0;
        if (s_tick && (state == ST_STOP) && (tick_cnt == TICK_LAST)) begin
            done_set = rx_s;
            ferr_set = !rx_s;
        end
    end

    // Registered outputs: strobes last one cycle, data only moves on a good frame.
    always_ff @(posedge clk) begin
        if (reset) begin
            data        <= '0;
            rx_done     <= 1'b0;
            frame_error <= 1'b0;
        end else begin
            rx_done     <= done_set;
            frame_error <= ferr_set;
            if (done_set) begin
                data <= shreg;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_rx
// Brief    : Directed self-checking bench for uart_rx with defaults
//            (8 data bits, 16x oversampling, s_tick every 4th clk).
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_rx;

    logic       clk = 1'b0;
    logic       reset;
    logic       s_tick;
    logic       rx;
    logic [7:0] data;
    logic       rx_done;
    logic       frame_error;

    uart_rx #(
        .DATA_BITS  (8),
        .OVERSAMPLE (16)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .s_tick      (s_tick),
        .rx          (rx),
        .data        (data),
        .rx_done     (rx_done),
        .frame_error (frame_error)
    );

    always #5 clk = ~clk;

    // s_tick: one clk wide, every 4th clk.
    logic [1:0] div = 2'd0;
    always @(posedge clk) div <= div + 2'd1;
    assign s_tick = (div == 2'd3);

    // Running count of s_tick edges seen.
    int tick_no = 0;
    always @(posedge clk) if (s_tick) tick_no <= tick_no + 1;

    // Monitor: count strobes and record received bytes, sampled mid-cycle.
    int         done_cnt  = 0;
    int         ferr_cnt  = 0;
    int         both_cnt  = 0;
    int         done_tick = 0;
    logic [7:0] rxq[$];

    always @(negedge clk) begin
        if (rx_done) begin
            done_cnt  = done_cnt + 1;
            done_tick = tick_no;
            rxq.push_back(data);
        end
        if (frame_error) ferr_cnt = ferr_cnt + 1;
        if (rx_done && frame_error) both_cnt = both_cnt + 1;
    end

    int vectors     = 0;
    int miscompares = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors = vectors + 1;
        if (got !== exp) begin
            miscompares = miscompares + 1;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Wait for n s_tick edges, then step 1 time unit past the last one.
    task automatic wait_ticks(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            while (!s_tick) @(posedge clk);
        end
        #1;
    endtask

    int t0 = 0;

    // One frame, 16 ticks per bit, starting immediately (caller is just
    // past a tick edge).
    task automatic send_frame(input logic [7:0] b, input logic stop);
        rx = 1'b0;
        t0 = tick_no;
        wait_ticks(16);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            wait_ticks(16);
        end
        rx = stop;
        wait_ticks(16);
    endtask

    int base_done;
    int base_ferr;

    initial begin
        reset = 1'b1;
        rx    = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        reset = 1'b0;

        // Reset state
        check("reset_data", {24'd0, data}, 32'h00);
        check("reset_done", {31'd0, rx_done}, 32'd0);
        check("reset_ferr", {31'd0, frame_error}, 32'd0);

        wait_ticks(20);

        // Single 0xA5 frame: done at detection tick + 152, detection is the
        // first tick after the line falls.
        send_frame(8'hA5, 1'b1);
        check("a5_done_cnt", done_cnt, 1);
        check("a5_data", {24'd0, data}, 32'hA5);
        check("a5_ferr_cnt", ferr_cnt, 0);
        check("a5_latency", done_tick - t0, 153);

        // Back-to-back 0x00 then 0xFF, no idle between frames.
        base_done = done_cnt;
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        wait_ticks(4);
        check("b2b_done_cnt", done_cnt, base_done + 2);
        check("b2b_first", {24'd0, rxq[base_done]}, 32'h00);
        check("b2b_second", {24'd0, rxq[base_done + 1]}, 32'hFF);
        check("b2b_ferr_cnt", ferr_cnt, 0);

        // Short glitch: low for 4 ticks only.
        wait_ticks(16);
        base_done = done_cnt;
        rx = 1'b0;
        wait_ticks(4);
        rx = 1'b1;
        wait_ticks(40);
        check("glitch_done_cnt", done_cnt, base_done);
        check("glitch_ferr_cnt", ferr_cnt, 0);

        send_frame(8'h3C, 1'b1);
        check("after_glitch_data", {24'd0, data}, 32'h3C);
        check("after_glitch_done_cnt", done_cnt, base_done + 1);

        // Framing error followed by a 3-bit-time break.
        wait_ticks(16);
        base_done = done_cnt;
        send_frame(8'h81, 1'b0);
        wait_ticks(48);
        check("ferr_cnt", ferr_cnt, 1);
        check("ferr_data_kept", {24'd0, data}, 32'h3C);
        check("ferr_no_done", done_cnt, base_done);
        rx = 1'b1;
        wait_ticks(16);
        send_frame(8'h42, 1'b1);
        check("after_break_data", {24'd0, data}, 32'h42);
        check("after_break_ferr_cnt", ferr_cnt, 1);

        // Reset mid-DATA, after bit 4 of a 0x99 frame has been sampled.
        wait_ticks(16);
        base_done = done_cnt;
        base_ferr = ferr_cnt;
        rx = 1'b0;
        wait_ticks(16);
        for (int i = 0; i < 6; i++) begin
            rx = 8'h99 >> i;
            wait_ticks(16);
        end
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        check("midreset_data", {24'd0, data}, 32'h00);
        check("midreset_done", {31'd0, rx_done}, 32'd0);
        check("midreset_ferr", {31'd0, frame_error}, 32'd0);
        rx = 1'b1;
        wait_ticks(200);
        check("midreset_no_done", done_cnt, base_done);
        check("midreset_no_ferr", ferr_cnt, base_ferr);
        send_frame(8'h5A, 1'b1);
        check("after_reset_data", {24'd0, data}, 32'h5A);
        check("after_reset_done_cnt", done_cnt, base_done + 1);

        // Transmitter-style traffic: one bit time per 16 ticks, one idle bit
        // between frames.
        base_done = done_cnt;
        rx = 1'b1;
        wait_ticks(16);
        send_frame(8'h55, 1'b1);
        wait_ticks(16);
        send_frame(8'hC3, 1'b1);
        wait_ticks(16);
        check("loop_done_cnt", done_cnt, base_done + 2);
        check("loop_first", {24'd0, rxq[base_done]}, 32'h55);
        check("loop_second", {24'd0, rxq[base_done + 1]}, 32'hC3);
        check("loop_ferr_cnt", ferr_cnt, base_ferr);

        check("done_and_ferr_together", both_cnt, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart_rx.md
# uart_rx

Serial UART receiver: the receive-side counterpart of the team's UART transmitter. It recovers 8N1 frames (one start bit, DATA_BITS data bits LSB-first, one stop bit) from the asynchronous `rx` line using a 16x oversampling tick, and presents each byte with a one-cycle done strobe. It sits between the pad/pin and the byte consumer (FIFO or register interface) and shares the `s_tick` baud generator with the transmitter.

## Interface
- `DATA_BITS`, 8: data bits per frame.
- `OVERSAMPLE`, 16: `s_tick` pulses per bit period; must be even and at least 4.

- `clk`  in  1  system clock; all logic on posedge.
- `reset`  in  1  reset, synchronous, active-high.
- `s_tick`  in  1  oversample enable, one `clk` wide, rate = baud × OVERSAMPLE.
- `rx`  in  1  asynchronous serial line; idle high.
- `data`  out  DATA_BITS  last correctly framed byte.
- `rx_done`  out  1  one-cycle pulse; `data` is valid and updated in this cycle.
- `frame_error`  out  1  one-cycle pulse; the stop bit was sampled low.

## Operation
- `rx` passes through a 2-flop synchronizer, reset to 1, giving `rx_s`. All decisions use `rx_s`, and only on cycles where `s_tick`=1.
- Counters:
  - `tick_cnt` is 0..OVERSAMPLE-1 and resets to 0 on every state change.
  - `bit_cnt` is 0..DATA_BITS-1.
  - Shift register `shreg` is DATA_BITS wide, shifts right, and takes new bits in at the MSB.
- IDLE: `rx_s`=0 → START.
- START: at `tick_cnt`=OVERSAMPLE/2-1 (mid start bit):
  - `rx_s`=0 → DATA, with `bit_cnt` set to 0.
  - `rx_s`=1 → glitch; return to IDLE with no output activity.
  - Otherwise increment `tick_cnt`.
- DATA: at `tick_cnt`=OVERSAMPLE-1, shift `rx_s` into `shreg`.
  - If `bit_cnt`=DATA_BITS-1 → STOP.
  - Otherwise increment `bit_cnt`.
- STOP: at `tick_cnt`=OVERSAMPLE-1:
  - `rx_s`=1 → `data`←`shreg`, `rx_done` pulses, go to IDLE.
  - `rx_s`=0 → `frame_error` pulses, `data` is unchanged, go to WAIT_HIGH.
- WAIT_HIGH: `rx_s`=1 → IDLE. A held-low line (break) produces no further frames or errors.
- `rx_done` and `frame_error` are never asserted in the same cycle.
- `data` holds its value until the next good frame.

## Timing
- Reset values:
  - `data`=0, `rx_done`=0, `frame_error`=0.
  - State=IDLE, counters=0, synchronizer flops=1.
- Reset takes effect on the next `clk` edge regardless of state. A frame in progress is abandoned silently: no `rx_done`, no `frame_error`.
- Input latency: 2 `clk` cycles (synchronizer).
- Frame latency: `rx_done` (or `frame_error`) is registered high in the `clk` cycle after the s_tick on which the stop sample is taken. With defaults, that s_tick is the 152nd after the tick that detected the start: 8 + 8×16 + 16. `rx_done` deasserts on the following `clk` cycle.
- Back-to-back frames: a new start bit can be detected on the first s_tick after returning to IDLE, i.e. half a bit into the stop bit at the earliest line position. Full-rate continuous traffic is received without loss.
- `s_tick` held low freezes the FSM and counters; no timeout.

## Structure
- Shared package `uart_pkg`, also used by the transmitter:
  - State encodings (IDLE, START, DATA, STOP, WAIT_HIGH).
  - Default DATA_BITS and OVERSAMPLE constants.
- Sub-module `uart_sync2`: 2-flop synchronizer with a parameterized reset value, reused for other async inputs.

## Test plan
- Reset, then a frame carrying 0xA5 at OVERSAMPLE=16 → `data`=0xA5, exactly one `rx_done` pulse 152 ticks (+ sync delay) after start detection, and `frame_error` stays 0.
- Back-to-back 0x00 then 0xFF with no idle gap → two `rx_done` pulses with `data`=0x00 then 0xFF, and no `frame_error`.
- `rx` low for 4 ticks, then high → no `rx_done`, no `frame_error`, FSM back in IDLE. A following 0x3C frame is received correctly.
- Frame 0x81 with stop bit driven 0, then `rx` held low for 3 bit times → one `frame_error` pulse, `data` keeps its previous value (0x3C), and no further pulses. When `rx` rises and a 0x42 frame follows → `data`=0x42.
- Assert `reset` for one cycle mid-DATA (after bit 4) → all outputs 0 next cycle, no pulses from the aborted frame. The next 0x5A frame is received correctly.
- Loopback: the team transmitter clocked on every 16th `s_tick`, sending 0x55 and 0xC3 → `uart_rx` reports both bytes in order with no errors.
